// File: rtl/ib_sched_pkg.sv
// Shared types for the IB decoder iteration scheduler: state encoding,
// default widths and bit positions of the handshake output vector.
package ib_sched_pkg;

  localparam int ITER_W_DEF    = 6;
  localparam int TIMEOUT_W_DEF = 8;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT_CNU = 4'd1,
    S_INIT_VNU = 4'd2,
    S_CNU_RUN  = 4'd3,
    S_CNU_UPD  = 4'd4,
    S_VNU_RUN  = 4'd5,
    S_VNU_UPD  = 4'd6,
    S_DONE     = 4'd7,
    S_ERR      = 4'd8
  } sched_state_e;

  localparam int HS_CNU_UPD  = 0;
  localparam int HS_CNU_RDF  = 1;
  localparam int HS_CNU_INIT = 2;
  localparam int HS_VNU_UPD  = 3;
  localparam int HS_VNU_RDF  = 4;
  localparam int HS_VNU_INIT = 5;
  localparam int HS_W        = 6;

  // Handshake drive pattern for each state; unlisted states drive nothing.
  function automatic logic [HS_W-1:0] hs_decode(input sched_state_e s);
    logic [HS_W-1:0] v;
    v = '0;
    case (s)
      S_INIT_CNU: begin v[HS_CNU_INIT] = 1'b1; v[HS_CNU_UPD] = 1'b1; end
      S_CNU_UPD:  begin v[HS_CNU_RDF]  = 1'b1; v[HS_CNU_UPD] = 1'b1; end
      S_INIT_VNU: begin v[HS_VNU_INIT] = 1'b1; v[HS_VNU_UPD] = 1'b1; end
      S_VNU_UPD:  begin v[HS_VNU_RDF]  = 1'b1; v[HS_VNU_UPD] = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic is_wait_state(input sched_state_e s);
    return (s == S_INIT_CNU) || (s == S_INIT_VNU) ||
           (s == S_CNU_UPD)  || (s == S_VNU_UPD);
  endfunction

endpackage

// File: rtl/ib_iter_update_scheduler_if.sv
// Control and handshake bundle between decode control, the scheduler and
// the CNU/VNU update handshakes. slave = scheduler, master = its environment.
interface ib_iter_update_scheduler_if #(
  parameter int ITER_W = ib_sched_pkg::ITER_W_DEF
);
  logic              decode_start_i;
  logic              abort_i;
  logic              early_term_i;
  logic [ITER_W-1:0] iter_max_i;
  logic              cnu_rd_done_i;
  logic              vnu_rd_done_i;
  logic              cnu_wr_i;
  logic              vnu_wr_i;
  logic              cnu_iter_update_o;
  logic              vnu_iter_update_o;
  logic              cnu_rd_finish_o;
  logic              vnu_rd_finish_o;
  logic              cnu_init_load_en_o;
  logic              vnu_init_load_en_o;
  logic [ITER_W-1:0] iter_cnt_o;
  logic              busy_o;
  logic              done_o;
  logic              timeout_err_o;

  modport slave (
    input  decode_start_i, abort_i, early_term_i, iter_max_i,
           cnu_rd_done_i, vnu_rd_done_i, cnu_wr_i, vnu_wr_i,
    output cnu_iter_update_o, vnu_iter_update_o, cnu_rd_finish_o,
           vnu_rd_finish_o, cnu_init_load_en_o, vnu_init_load_en_o,
           iter_cnt_o, busy_o, done_o, timeout_err_o
  );

  modport master (
    output decode_start_i, abort_i, early_term_i, iter_max_i,
           cnu_rd_done_i, vnu_rd_done_i, cnu_wr_i, vnu_wr_i,
    input  cnu_iter_update_o, vnu_iter_update_o, cnu_rd_finish_o,
           vnu_rd_finish_o, cnu_init_load_en_o, vnu_init_load_en_o,
           iter_cnt_o, busy_o, done_o, timeout_err_o
  );
endinterface

// File: rtl/ib_update_ack_det.sv
// Falling-edge detector on a handshake write flag; ack is combinational from
// a one-cycle history, so a flag already high on state entry is not an ack.
module ib_update_ack_det (
  input  logic read_clk,
  input  logic rstn,
  input  logic clr,
  input  logic wr,
  output logic ack
);

  logic wr_hist;

  always_ff @(posedge read_clk) begin
    if (!rstn || clr) wr_hist <= 1'b0;
    else              wr_hist <= wr;
  end

  assign ack = wr_hist & ~wr;

endmodule

// File: rtl/ib_iter_update_scheduler.sv
// Iteration scheduler for the IB LUT decoder: sequences CNU/VNU update handshakes,
// Moore outputs one cycle after the triggering input, watchdog on every wait state.
module ib_iter_update_scheduler
  import ib_sched_pkg::*;
#(
  parameter int ITER_W    = ITER_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                       read_clk,
  input  logic                       rstn,
  ib_iter_update_scheduler_if.slave  bus
);

  localparam logic [TIMEOUT_W-1:0] WD_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [ITER_W-1:0]    ITER_SAT = '1;

  sched_state_e      state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [ITER_W-1:0] iter_cnt_q, iter_max_q, iter_inc;
  logic              timeout_err_q;
  logic              cnu_ack, vnu_ack;
  logic              state_chg, wd_fire, start_acc;
  logic [HS_W-1:0]   hs;

  assign state_chg = (state_d != state_q);
  assign wd_fire   = (wd_q == WD_LAST);
  assign start_acc = (state_q == S_IDLE) && bus.decode_start_i && !bus.abort_i;
  assign iter_inc  = (iter_cnt_q == ITER_SAT) ? iter_cnt_q : iter_cnt_q + ITER_W'(1);

  // Histories restart on every state change so edges never carry across states.
  ib_update_ack_det u_cnu_ack (
    .read_clk (read_clk),
    .rstn     (rstn),
    .clr      (state_chg),
    .wr       (bus.cnu_wr_i),
    .ack      (cnu_ack)
  );

  ib_update_ack_det u_vnu_ack (
    .read_clk (read_clk),
    .rstn     (rstn),
    .clr      (state_chg),
    .wr       (bus.vnu_wr_i),
    .ack      (vnu_ack)
  );

  always_ff @(posedge read_clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (start_acc) state_d = S_INIT_CNU;
    end else if (bus.abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_INIT_CNU: begin
          if (cnu_ack)      state_d = S_INIT_VNU;
          else if (wd_fire) state_d = S_ERR;
        end
        S_INIT_VNU: begin
          if (vnu_ack)      state_d = S_CNU_RUN;
          else if (wd_fire) state_d = S_ERR;
        end
        S_CNU_RUN: if (bus.cnu_rd_done_i) state_d = S_CNU_UPD;
        S_CNU_UPD: begin
          if (cnu_ack)      state_d = S_VNU_RUN;
          else if (wd_fire) state_d = S_ERR;
        end
        S_VNU_RUN: if (bus.vnu_rd_done_i) state_d = S_VNU_UPD;
        S_VNU_UPD: begin
          if (vnu_ack) begin
            if (bus.early_term_i || (iter_inc >= iter_max_q)) state_d = S_DONE;
            else                                              state_d = S_CNU_RUN;
          end else if (wd_fire) begin
            state_d = S_ERR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hs                     = hs_decode(state_q);
    bus.cnu_iter_update_o  = hs[HS_CNU_UPD];
    bus.cnu_rd_finish_o    = hs[HS_CNU_RDF];
    bus.cnu_init_load_en_o = hs[HS_CNU_INIT];
    bus.vnu_iter_update_o  = hs[HS_VNU_UPD];
    bus.vnu_rd_finish_o    = hs[HS_VNU_RDF];
    bus.vnu_init_load_en_o = hs[HS_VNU_INIT];
    bus.busy_o             = (state_q != S_IDLE);
    bus.done_o             = (state_q == S_DONE);
    bus.iter_cnt_o         = iter_cnt_q;
    bus.timeout_err_o      = timeout_err_q;
  end

  // Watchdog counts only while a handshake owes us an ack.
  always_ff @(posedge read_clk) begin
    if (!rstn || state_chg || !is_wait_state(state_q)) wd_q <= '0;
    else                                               wd_q <= wd_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      iter_cnt_q    <= '0;
      iter_max_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (start_acc) begin
        iter_cnt_q    <= '0;
        iter_max_q    <= (bus.iter_max_i == '0) ? ITER_W'(1) : bus.iter_max_i;
        timeout_err_q <= 1'b0;
      end else begin
        if ((state_q == S_VNU_UPD) && vnu_ack && !bus.abort_i) iter_cnt_q <= iter_inc;
        if (state_d == S_ERR) timeout_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ib_iter_update_scheduler.sv
// Directed bench for ib_iter_update_scheduler: behavioural handshake responders
// acking two cycles after each update request, cycle-indexed decode monitor.
module tb_ib_iter_update_scheduler;

  logic read_clk;
  logic rstn;

  ib_iter_update_scheduler_if #(.ITER_W(6)) bus ();

  ib_iter_update_scheduler #(.ITER_W(6), .TIMEOUT_W(4)) dut (
    .read_clk (read_clk),
    .rstn     (rstn),
    .bus      (bus)
  );

  localparam logic [5:0] HS_NONE     = 6'b000000;
  localparam logic [5:0] HS_INIT_CNU = 6'b000101;
  localparam logic [5:0] HS_CNU_UPD  = 6'b000011;
  localparam logic [5:0] HS_INIT_VNU = 6'b101000;
  localparam logic [5:0] HS_VNU_UPD  = 6'b011000;

  int n_vec = 0;
  int n_err = 0;

  bit cnu_resp_en;
  bit vnu_resp_en;

  logic [5:0] hs_log   [256];
  logic       busy_log [256];
  logic [5:0] iter_log [256];
  int         iter_chg [$];
  int         done_cyc, n_done, end_cyc, err_cyc, iter_at_done;

  initial begin
    read_clk = 1'b0;
    forever #5 read_clk = ~read_clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [5:0] hs_vec();
    return {bus.vnu_init_load_en_o, bus.vnu_rd_finish_o, bus.vnu_iter_update_o,
            bus.cnu_init_load_en_o, bus.cnu_rd_finish_o, bus.cnu_iter_update_o};
  endfunction

  // Handshake responders: wr high on the 2nd cycle of a request, falls on the 3rd.
  initial begin
    int cnt = 0;
    bus.cnu_wr_i = 1'b0;
    forever begin
      @(negedge read_clk);
      if (!cnu_resp_en || bus.cnu_iter_update_o !== 1'b1) begin
        cnt = 0; bus.cnu_wr_i = 1'b0;
      end else begin
        cnt++; bus.cnu_wr_i = (cnt == 2);
      end
    end
  end

  initial begin
    int cnt = 0;
    bus.vnu_wr_i = 1'b0;
    forever begin
      @(negedge read_clk);
      if (!vnu_resp_en || bus.vnu_iter_update_o !== 1'b1) begin
        cnt = 0; bus.vnu_wr_i = 1'b0;
      end else begin
        cnt++; bus.vnu_wr_i = (cnt == 2);
      end
    end
  end

  // Cycle k = the cycle after the k-th rising edge following the start pulse.
  task automatic run_decode(input int imax, input int et_after, input int abort_at,
                            input int rst_at, input bit stray);
    done_cyc = -1; n_done = 0; end_cyc = -1; err_cyc = -1; iter_at_done = -1;
    iter_chg.delete();
    @(negedge read_clk);
    bus.iter_max_i     = 6'(imax);
    bus.decode_start_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge read_clk);
      bus.decode_start_i = 1'b0;
      bus.abort_i        = 1'b0;
      rstn               = 1'b1;
      hs_log[k]   = hs_vec();
      busy_log[k] = bus.busy_o;
      iter_log[k] = bus.iter_cnt_o;
      if (bus.done_o) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = k; iter_at_done = int'(bus.iter_cnt_o); end
      end
      if (bus.timeout_err_o && err_cyc < 0) err_cyc = k;
      if (k > 0 && iter_log[k] != iter_log[k-1]) iter_chg.push_back(k);
      if (!bus.busy_o) begin end_cyc = k; break; end
      bus.cnu_rd_done_i = 1'b1;
      bus.vnu_rd_done_i = stray ? (k == 6 || k >= 14) : 1'b1;
      if (et_after >= 0 && int'(bus.iter_cnt_o) >= et_after) bus.early_term_i = 1'b1;
      if (k == abort_at) bus.abort_i = 1'b1;
      if (k == rst_at)   rstn = 1'b0;
    end
    bus.cnu_rd_done_i = 1'b0;
    bus.vnu_rd_done_i = 1'b0;
    bus.early_term_i  = 1'b0;
    check_eq("decode_terminated", (end_cyc >= 0), 1);
  endtask

  initial begin
    rstn = 1'b0;
    bus.decode_start_i = 1'b0; bus.abort_i = 1'b0; bus.early_term_i = 1'b0;
    bus.iter_max_i = '0; bus.cnu_rd_done_i = 1'b0; bus.vnu_rd_done_i = 1'b0;
    cnu_resp_en = 1'b1; vnu_resp_en = 1'b1;

    repeat (3) @(negedge read_clk);
    check_eq("rst_busy", bus.busy_o, 0);
    check_eq("rst_done", bus.done_o, 0);
    check_eq("rst_hs", hs_vec(), HS_NONE);
    check_eq("rst_iter", bus.iter_cnt_o, 0);
    check_eq("rst_terr", bus.timeout_err_o, 0);
    rstn = 1'b1;

    // Normal decode, three iterations of 8 cycles after a 6-cycle init.
    run_decode(3, -1, -1, -1, 1'b0);
    check_eq("norm_hs_init_cnu", hs_log[0], HS_INIT_CNU);
    check_eq("norm_hs_init_vnu", hs_log[3], HS_INIT_VNU);
    check_eq("norm_hs_cnu_run", hs_log[6], HS_NONE);
    check_eq("norm_hs_cnu_upd", hs_log[7], HS_CNU_UPD);
    check_eq("norm_hs_vnu_upd", hs_log[11], HS_VNU_UPD);
    check_eq("norm_done_cyc", done_cyc, 30);
    check_eq("norm_n_done", n_done, 1);
    check_eq("norm_iter_done", iter_at_done, 3);
    check_eq("norm_busy_in_done", busy_log[30], 1);
    check_eq("norm_n_iter_steps", iter_chg.size(), 3);
    if (iter_chg.size() == 3) begin
      check_eq("norm_iter1_cyc", iter_chg[0], 14);
      check_eq("norm_iter2_cyc", iter_chg[1], 22);
      check_eq("norm_iter3_cyc", iter_chg[2], 30);
    end
    check_eq("norm_end_cyc", end_cyc, 31);
    @(negedge read_clk);
    check_eq("norm_iter_hold", bus.iter_cnt_o, 3);

    // Early termination raised once the first iteration is complete.
    run_decode(10, 1, -1, -1, 1'b0);
    check_eq("et_start_clears_iter", iter_log[0], 0);
    check_eq("et_done_cyc", done_cyc, 22);
    check_eq("et_iter_done", iter_at_done, 2);
    check_eq("et_n_done", n_done, 1);

    // iter_max 0 acts as 1; a stray VNU read-done during CNU_RUN must not stick.
    run_decode(0, -1, -1, -1, 1'b1);
    check_eq("max0_hs_vnu_run", hs_log[12], HS_NONE);
    check_eq("max0_busy_vnu_run", busy_log[12], 1);
    check_eq("max0_done_cyc", done_cyc, 18);
    check_eq("max0_iter_done", iter_at_done, 1);

    // Watchdog: no CNU ack in INIT_CNU.
    cnu_resp_en = 1'b0;
    run_decode(3, -1, -1, -1, 1'b0);
    cnu_resp_en = 1'b1;
    check_eq("wd_hs_last_wait", hs_log[14], HS_INIT_CNU);
    check_eq("wd_err_cyc", err_cyc, 15);
    check_eq("wd_hs_err", hs_log[15], HS_NONE);
    check_eq("wd_busy_err", busy_log[15], 1);
    check_eq("wd_end_cyc", end_cyc, 16);
    check_eq("wd_no_done", n_done, 0);
    repeat (3) @(negedge read_clk);
    check_eq("wd_sticky", bus.timeout_err_o, 1);

    // Abort in the second CNU_UPD; next start clears the error too.
    run_decode(3, -1, 16, -1, 1'b0);
    check_eq("abort_terr_cleared", err_cyc, -1);
    check_eq("abort_hs_cnu_upd", hs_log[16], HS_CNU_UPD);
    check_eq("abort_end_cyc", end_cyc, 17);
    check_eq("abort_hs_idle", hs_log[17], HS_NONE);
    check_eq("abort_no_done", n_done, 0);
    check_eq("abort_iter_hold", iter_log[17], 1);
    run_decode(3, -1, -1, -1, 1'b0);
    check_eq("abort_restart_iter", iter_log[0], 0);

    // Synchronous reset during the second VNU_RUN.
    run_decode(3, -1, -1, 18, 1'b0);
    check_eq("rst_mid_end_cyc", end_cyc, 19);
    check_eq("rst_mid_hs", hs_log[19], HS_NONE);
    check_eq("rst_mid_iter", iter_log[19], 0);
    check_eq("rst_mid_no_done", n_done, 0);

    // Start and abort together in IDLE.
    @(negedge read_clk);
    bus.iter_max_i = 6'd3; bus.decode_start_i = 1'b1; bus.abort_i = 1'b1;
    @(negedge read_clk);
    bus.decode_start_i = 1'b0; bus.abort_i = 1'b0;
    check_eq("start_abort_busy", bus.busy_o, 0);
    check_eq("start_abort_hs", hs_vec(), HS_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ib_iter_update_scheduler.md
# ib_iter_update_scheduler

Decoding-iteration scheduler for the Information-Bottleneck LUT decoder. It sequences the CNU and VNU LUT-update handshakes: the initial load, then alternating per-iteration pipe loads. It drives each handshake's iteration-update, read-finish and init-load-enable inputs, and consumes their write/load status. It sits between the top-level decode control (start/abort/early-termination) and the `cnu_wr_update_handshake` / `vnu_wr_update_handshake` instances, and counts iterations up to a runtime maximum.

## Interface
- `ITER_W`, 6: width of the iteration counter and of `iter_max_i`.
- `TIMEOUT_W`, 8: width of the handshake watchdog counter. Timeout fires after 2^TIMEOUT_W−1 wait cycles.
- `read_clk` in 1: single clock. All state changes on the rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `decode_start_i` in 1: one-cycle start pulse. Ignored unless in IDLE.
- `abort_i` in 1: abandon the current decode.
- `early_term_i` in 1: syndrome-zero flag from the datapath. Sampled only at the end of a VNU update.
- `iter_max_i` in ITER_W: maximum iterations. Sampled on start. A value of 0 is treated as 1.
- `cnu_rd_done_i`, `vnu_rd_done_i` in 1: datapath has finished reading that LUT set this iteration.
- `cnu_wr_i`, `vnu_wr_i` in 1: write flag returned by each handshake.
- `cnu_iter_update_o`, `vnu_iter_update_o` out 1: to the handshake `iter_update_i`.
- `cnu_rd_finish_o`, `vnu_rd_finish_o` out 1: to the handshake `rd_finish_i`.
- `cnu_init_load_en_o`, `vnu_init_load_en_o` out 1: to the handshake `init_load_en_i`.
- `iter_cnt_o` out ITER_W: number of completed iterations.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when a decode completes normally.
- `timeout_err_o` out 1: sticky watchdog error. Cleared only by reset or `decode_start_i`.

## Operation
- States and transitions:
  - IDLE → INIT_CNU on `decode_start_i`.
  - INIT_CNU → INIT_VNU on CNU update ack.
  - INIT_VNU → CNU_RUN on VNU update ack.
  - CNU_RUN → CNU_UPD on `cnu_rd_done_i`.
  - CNU_UPD → VNU_RUN on CNU ack.
  - VNU_RUN → VNU_UPD on `vnu_rd_done_i`.
  - VNU_UPD on VNU ack: iteration completes (see the VNU_UPD bullet below).
  - DONE → IDLE unconditionally.
  - ERR → IDLE unconditionally.
- Update ack for a unit: its `wr_i` was 1 in the previous cycle and is 0 in the current cycle. The scheduler keeps a one-cycle history register per unit. A `wr_i` high on the state-entry cycle is not an ack by itself.
- INIT_x: `x_init_load_en_o`=1 and `x_iter_update_o`=1. All other x outputs are 0.
- x_UPD: `x_rd_finish_o`=1 and `x_iter_update_o`=1.
- x_RUN: all x outputs are 0.
- Outputs of the unit not being serviced are held at 0.
- VNU_UPD on VNU ack:
  - `iter_cnt` increments.
  - If `early_term_i`=1 or the new `iter_cnt` ≥ `iter_max`, go to DONE.
  - Otherwise go to CNU_RUN.
- `iter_cnt` is cleared on `decode_start_i`. It saturates at 2^ITER_W−1 and holds its value in IDLE/DONE until the next start.
- Watchdog:
  - Reloads to 0 on every state change.
  - Counts while in INIT_x or x_UPD.
  - At all-ones, go to ERR: set `timeout_err_o`, deassert all handshake outputs.
  - The RUN states have no watchdog.
- `abort_i` has priority over every transition except reset. From any non-IDLE state, the next state is IDLE with all outputs 0. No `done_o` is produced.
- In IDLE, `decode_start_i` and `abort_i` asserted together: abort wins and the scheduler stays in IDLE.
- `x_rd_done_i` outside x_RUN is ignored; it is not latched.

## Timing
- Reset (`rstn`=0 at a rising edge):
  - State becomes IDLE.
  - All outputs 0, `iter_cnt_o`=0, watchdog and ack histories cleared.
  - This applies mid-decode as well.
- All outputs are registered Moore outputs, decoded from the state register. They change in the cycle after the triggering input edge.
- Latency:
  - start → `cnu_init_load_en_o` high: 1 cycle.
  - ack detect → next state: 1 cycle.
  - `done_o` high for exactly the single DONE cycle, with `busy_o` still 1.
- Minimum iteration time: 4 state cycles plus the handshake write windows.
- The handshake instances see `iter_update` held level-high for the whole x_UPD/INIT_x state and dropped on exit.

## Structure
- Shared package `ib_sched_pkg`: state enum (9 states, 4-bit encoding), `ITER_W`/`TIMEOUT_W` defaults, output-vector bit indices.
- One sub-module, `ib_update_ack_det`:
  - Per-unit falling-edge detector on `wr_i` with a clear input.
  - Instantiated twice, for CNU and VNU.
- The FSM, iteration counter and watchdog stay in the top.

## Test plan
- Normal decode: `iter_max_i`=3, acks 2 cycles after each update request, `early_term_i`=0 → `iter_cnt_o` sequence 1,2,3, `done_o` pulse once, then IDLE, `busy_o`=0.
- Early termination: `iter_max_i`=10, `early_term_i`=1 at the 2nd VNU ack → DONE with `iter_cnt_o`=2.
- Watchdog: `cnu_wr_i` held 0 in INIT_CNU with `TIMEOUT_W`=4 → ERR after 15 cycles, `timeout_err_o`=1 sticky, all handshake outputs 0.
- Abort mid CNU_UPD → IDLE next cycle, no `done_o`, and the next `decode_start_i` clears `iter_cnt_o` to 0.
- Synchronous reset asserted in VNU_RUN → all outputs 0 at that edge. Start simultaneous with abort in IDLE → stays IDLE.
- `iter_max_i`=0 → exactly one iteration then `done_o`. Stray `vnu_rd_done_i` during CNU_RUN is ignored.
